// File: rtl/pci_initiator_pkg.sv
// Shared PCI initiator definitions: bus command codes, idle byte-enable value, FSM state encoding.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pci_initiator_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [3:0] CBE_IDLE      = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_MABORT = 3'd3,
        ST_TAIL   = 3'd4
    } state_t;

    // Only memory read and memory write start a bus transaction.
    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_WRITE);
    endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// Local request port plus PCI control signals (AD is a separate inout on the initiator).
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready handshake; target stalls via trdy (and stop with PCI_INIT_STOP_EN).
// Ports: master = initiator view, slave = requester/target view. Macro: PCI_INIT_STOP_EN adds stop.
interface pci_initiator_if #(
    parameter int LEN_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cmd;
    logic [31:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic [31:0]      wr_data;
    logic [3:0]       wr_be;
    logic             wr_pop;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             done;
    logic             abort;
    logic             frame;
    logic             irdy;
    logic [3:0]       cbe;
    logic             trdy;
    logic             devsel;
`ifdef PCI_INIT_STOP_EN
    logic             stop;
`endif

    modport master (
`ifdef PCI_INIT_STOP_EN
        input  stop,
`endif
        input  req_valid, req_cmd, req_addr, req_len, wr_data, wr_be, trdy, devsel,
        output req_ready, wr_pop, rd_data, rd_valid, done, abort, frame, irdy, cbe
    );

    modport slave (
`ifdef PCI_INIT_STOP_EN
        output stop,
`endif
        output req_valid, req_cmd, req_addr, req_len, wr_data, wr_be, trdy, devsel,
        input  req_ready, wr_pop, rd_data, rd_valid, done, abort, frame, irdy, cbe
    );

endinterface

// File: rtl/pci_initiator_devsel_timer.sv
// Counts consecutive data-phase clocks with DEVSEL deasserted; flags master abort at TIMEOUT.
// Latency: timeout is combinational in the TIMEOUT-th consecutive unclaimed data clock.
// Backpressure: none. Ports: clk, rst, en (in data phase), devsel (active-low), timeout.
module pci_initiator_devsel_timer #(
    parameter int TIMEOUT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic devsel,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Gated by devsel so a claim arriving in the expiring clock wins over the abort.
    assign timeout = en && devsel && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !en || !devsel) begin
            cnt <= '0;
        end else if (!timeout) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: single/burst memory read and write from a local valid/ready request port.
// Latency: request -> 1 address clk -> data clks (1 per beat + target waits) -> 1 turnaround clk with done.
// Backpressure: req_ready only in IDLE; target wait states (trdy=1) hold all bus outputs.
// Ports: clk, rst (sync, active-high), bus (pci_initiator_if.master), ad (32-bit tri-state AD).
// Macro: PCI_INIT_STOP_EN adds target STOP handling (disconnect / retry).
module pci_initiator
    import pci_initiator_pkg::*;
#(
    parameter int MAX_BURST      = 8,
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int LEN_W          = 4
) (
    input  logic            clk,
    input  logic            rst,
    pci_initiator_if.master bus,
    inout  wire  [31:0]     ad
);

    state_t           state, state_n;
    logic [3:0]       cmd_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] beats_q;
    logic [LEN_W-1:0] len_clamped;
    logic [31:0]      rd_data_q;
    logic             rd_valid_q, done_q, abort_q;
    logic             accept, is_wr, beat_done, last_beat, timeout, stop_req;
    logic             bad_cmd, end_abort;
    logic             frame, irdy, ad_oe;
    logic [3:0]       cbe;
    logic [31:0]      ad_out;

    assign bus.req_ready = (state == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_wr         = (cmd_q == CMD_MEM_WRITE);
    // IRDY is always asserted in DATA, so a beat needs only TRDY and DEVSEL.
    assign beat_done     = (state == ST_DATA) && !bus.trdy && !bus.devsel;
    assign last_beat     = (beats_q == LEN_W'(1));

`ifdef PCI_INIT_STOP_EN
    assign stop_req = (state == ST_DATA) && !bus.stop;
`else
    assign stop_req = 1'b0;
`endif

    always_comb begin
        if (bus.req_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (int'(bus.req_len) > MAX_BURST) begin
            len_clamped = LEN_W'(MAX_BURST);
        end else begin
            len_clamped = bus.req_len;
        end
    end

    pci_initiator_devsel_timer #(
        .TIMEOUT (DEVSEL_TIMEOUT)
    ) u_devsel_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_DATA),
        .devsel  (bus.devsel),
        .timeout (timeout)
    );

    always_comb begin
        state_n   = state;
        bad_cmd   = 1'b0;
        end_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_supported(bus.req_cmd)) begin
                        state_n = ST_ADDR;
                    end else begin
                        bad_cmd = 1'b1;
                    end
                end
            end
            ST_ADDR: state_n = ST_DATA;
            ST_DATA: begin
                if (beat_done && (last_beat || stop_req)) begin
                    state_n = ST_TAIL;          // normal end or disconnect
                end else if (stop_req) begin
                    state_n   = ST_TAIL;        // retry: no beat moved this clock
                    end_abort = 1'b1;
                end else if (timeout) begin
                    state_n = ST_MABORT;
                end
            end
            ST_MABORT: begin
                state_n   = ST_TAIL;
                end_abort = 1'b1;
            end
            ST_TAIL: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Bus drive is purely a function of state and the held write beat, so wait states hold it.
    always_comb begin
        frame  = 1'b1;
        irdy   = 1'b1;
        cbe    = CBE_IDLE;
        ad_oe  = 1'b0;
        ad_out = addr_q;
        case (state)
            ST_ADDR: begin
                frame = 1'b0;
                cbe   = cmd_q;
                ad_oe = 1'b1;
            end
            ST_DATA: begin
                frame  = last_beat;
                irdy   = 1'b0;
                cbe    = is_wr ? bus.wr_be : 4'h0;
                ad_oe  = is_wr;
                ad_out = bus.wr_data;
            end
            ST_MABORT: irdy = 1'b0;
            default: ;
        endcase
    end

    assign ad           = ad_oe ? ad_out : 32'bz;
    assign bus.frame    = frame;
    assign bus.irdy     = irdy;
    assign bus.cbe      = cbe;
    assign bus.wr_pop   = beat_done && is_wr;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.done     = done_q;
    assign bus.abort    = abort_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd_q      <= CBE_IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state      <= state_n;
            rd_valid_q <= beat_done && !is_wr;
            if (beat_done && !is_wr) begin
                rd_data_q <= ad;
            end
            // done/abort are high during the TAIL clock, or the clock after a rejected command.
            done_q  <= bad_cmd || (state_n == ST_TAIL);
            abort_q <= bad_cmd || end_abort;
            if (accept) begin
                cmd_q   <= bus.req_cmd;
                addr_q  <= bus.req_addr;
                beats_q <= len_clamped;
            end else if (beat_done) begin
                beats_q <= beats_q - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pci_initiator.sv
// Self-checking bench for pci_initiator: directed transactions with a scripted PCI target.
// Latency: n/a. Backpressure: target inserts wait states, late claims, and (with PCI_INIT_STOP_EN) stops.
module tb_pci_initiator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pci_initiator_if #(.LEN_W(4)) bus ();

    logic        tgt_oe;
    logic [31:0] tgt_ad;
    wire  [31:0] ad;
    assign ad = tgt_oe ? tgt_ad : 32'bz;

    pci_initiator #(
        .MAX_BURST      (8),
        .DEVSEL_TIMEOUT (5),
        .LEN_W          (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .ad  (ad)
    );

    localparam logic [31:0] HIZ_PAT = 32'h5A5A_A5A5;

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0] pop_q[$];    // {expected frame, expected AD} per accepted write beat
    logic [31:0] rd_q[$];     // expected read data per rd_valid pulse
    logic        abort_q[$];  // expected abort value per done pulse
    logic [32:0] mon_pop;
    logic [31:0] mon_rd;
    logic        mon_ab;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_dat(input logic [31:0] base, input int i);
        return base + 32'h0101_0101 * i;
    endfunction

    // Monitor: sampled late in the low clock phase, after the bench has driven the cycle's inputs.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (bus.wr_pop) begin
                if (pop_q.size() == 0) begin
                    chk("wr_pop_unexpected", bus.wr_pop, 1'b0);
                end else begin
                    mon_pop = pop_q.pop_front();
                    chk("wr_pop_beat", {bus.frame, ad}, mon_pop);
                end
            end
            if (bus.rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_valid_unexpected", bus.rd_valid, 1'b0);
                end else begin
                    mon_rd = rd_q.pop_front();
                    chk("rd_data", bus.rd_data, mon_rd);
                end
            end
            if (bus.done) begin
                if (abort_q.size() == 0) begin
                    chk("done_unexpected", bus.done, 1'b0);
                end else begin
                    mon_ab = abort_q.pop_front();
                    chk("done_abort", bus.abort, mon_ab);
                end
            end else if (bus.abort) begin
                chk("abort_without_done", bus.abort, 1'b0);
            end
        end
    end

    task automatic set_target_idle();
        bus.trdy   = 1'b1;
        bus.devsel = 1'b1;
`ifdef PCI_INIT_STOP_EN
        bus.stop   = 1'b1;
`endif
    endtask

    // claim_delay: data clocks before DEVSEL asserts (>=5 means never -> master abort).
    // wait_beat/nwait: TRDY wait clocks before that beat. stop_beat: STOP on that beat (-1 = none).
    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] addr, input int len,
                           input logic [31:0] base, input int wait_beat, input int nwait,
                           input int claim_delay, input int stop_beat);
        int elen, nbeats, b, k, waits_left;
        bit wr, bad, abort_case, retry, fin, claimed, s, tr;
        wr         = (cmd == 4'b0111);
        bad        = (cmd != 4'b0111) && (cmd != 4'b0110);
        elen       = (len == 0) ? 1 : ((len > 8) ? 8 : len);
        abort_case = (claim_delay >= 5);
        retry      = (stop_beat >= 0) && (wait_beat == stop_beat) && (nwait > 0);
        if (abort_case)          nbeats = 0;
        else if (stop_beat >= 0) nbeats = retry ? stop_beat : stop_beat + 1;
        else                     nbeats = elen;
        if (!bad) begin
            for (int i = 0; i < nbeats; i++) begin
                if (wr) pop_q.push_back({(i == elen - 1), beat_dat(base, i)});
                else    rd_q.push_back(beat_dat(base, i));
            end
        end
        abort_q.push_back(bad || abort_case || retry);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_addr  = addr;
        bus.req_len   = 4'(len);
        bus.wr_data   = wr ? base : 32'hDEAD_BEEF;
        bus.wr_be     = 4'h3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        if (bad) begin
            chk("bad_no_frame", bus.frame, 1'b1);
            chk("bad_ready", bus.req_ready, 1'b1);
            @(negedge clk);
            return;
        end
        chk("addr_frame", bus.frame, 1'b0);
        chk("addr_irdy", bus.irdy, 1'b1);
        chk("addr_cbe", bus.cbe, cmd);
        chk("addr_ad", ad, addr);

        b = 0; k = 0; waits_left = nwait; fin = 0;
        while (!fin) begin
            @(negedge clk);
            claimed = (k >= claim_delay);
            tr = 0;
            if (claimed) begin
                if (b == wait_beat && waits_left > 0) waits_left--;
                else tr = 1;
            end
            s = (stop_beat >= 0) && (b == stop_beat);
            bus.devsel  = !claimed;
            bus.trdy    = !tr;
`ifdef PCI_INIT_STOP_EN
            bus.stop    = !s;
`endif
            bus.wr_data = wr ? beat_dat(base, b) : 32'hDEAD_BEEF;
            bus.wr_be   = wr ? 4'(b + 3) : 4'h3;
            tgt_oe      = !wr;
            tgt_ad      = beat_dat(base, b);
            #1;
            chk("data_irdy", bus.irdy, 1'b0);
            chk("data_frame", bus.frame, (b == elen - 1));
            chk("data_cbe", bus.cbe, wr ? 4'(b + 3) : 4'h0);
            chk("data_ad", ad, beat_dat(base, b));
            @(posedge clk);
            k++;
            if (tr) begin
                b++;
                if (b == elen || s) fin = 1;
            end else if (s) begin
                fin = 1;
            end else if (abort_case && k == 5) begin
                fin = 1;
            end
            if (k > 40) begin
                chk("data_phase_bound", k, 40);
                fin = 1;
            end
        end

        @(negedge clk);
        set_target_idle();
        tgt_oe = 1'b1;
        tgt_ad = HIZ_PAT;
        if (abort_case) begin
            #1;
            chk("mabort_frame", bus.frame, 1'b1);
            chk("mabort_irdy", bus.irdy, 1'b0);
            chk("mabort_ad_hiz", ad, HIZ_PAT);
            @(negedge clk);
        end
        #1;
        chk("tail_frame", bus.frame, 1'b1);
        chk("tail_irdy", bus.irdy, 1'b1);
        chk("tail_cbe", bus.cbe, 4'hF);
        chk("tail_ad_hiz", ad, HIZ_PAT);
        @(negedge clk);
        tgt_oe = 1'b0;
        #1;
        chk("idle_ready", bus.req_ready, 1'b1);
    endtask

    task automatic reset_mid_burst();
        pop_q.push_back({1'b0, beat_dat(32'h1234_0000, 0)});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 4'b0111;
        bus.req_addr  = 32'h0000_0080;
        bus.req_len   = 4'd4;
        bus.wr_data   = beat_dat(32'h1234_0000, 0);
        bus.wr_be     = 4'h3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.devsel = 1'b0;
        bus.trdy   = 1'b0;
        @(negedge clk);
        bus.wr_data = beat_dat(32'h1234_0000, 1);
        bus.trdy    = 1'b1;
        rst         = 1'b1;
        @(negedge clk);
        set_target_idle();
        tgt_oe = 1'b1;
        tgt_ad = HIZ_PAT;
        #1;
        chk("rst_frame", bus.frame, 1'b1);
        chk("rst_irdy", bus.irdy, 1'b1);
        chk("rst_cbe", bus.cbe, 4'hF);
        chk("rst_ad_hiz", ad, HIZ_PAT);
        chk("rst_ready_low", bus.req_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        tgt_oe = 1'b0;
        #1;
        chk("rst_ready_after", bus.req_ready, 1'b1);
        chk("rst_no_done", bus.done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal;
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 4'h0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_data   = '0;
        bus.wr_be     = 4'hF;
        set_target_idle();
        tgt_oe = 1'b1;
        tgt_ad = HIZ_PAT;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_frame", bus.frame, 1'b1);
        chk("reset_irdy", bus.irdy, 1'b1);
        chk("reset_cbe", bus.cbe, 4'hF);
        chk("reset_ad_hiz", ad, HIZ_PAT);
        chk("reset_outs", {bus.wr_pop, bus.rd_valid, bus.done, bus.abort}, 4'b0000);
        chk("reset_rd_data", bus.rd_data, 32'h0);
        chk("reset_ready", bus.req_ready, 1'b0);
        rst    = 1'b0;
        tgt_oe = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_reset", bus.req_ready, 1'b1);

        run_txn(4'b0111, 32'h0000_0000, 1,  32'h0000_F0F0, -1, 0, 0,  -1); // single write
        run_txn(4'b0110, 32'h0000_0000, 1,  32'h0000_FFFF, -1, 0, 0,  -1); // single read
        run_txn(4'b0111, 32'h0000_0040, 4,  32'h1000_0001,  1, 2, 0,  -1); // burst write, waits on beat 2
        run_txn(4'b0110, 32'h0000_0200, 3,  32'hC0DE_0000,  0, 1, 0,  -1); // burst read, wait on beat 1
        run_txn(4'b0111, 32'h0000_0300, 0,  32'h0000_0055, -1, 0, 0,  -1); // len 0 -> 1 beat
        run_txn(4'b0110, 32'h0000_0400, 12, 32'h0000_1000, -1, 0, 0,  -1); // len 12 clamped to 8
        run_txn(4'b0111, 32'h0000_0500, 2,  32'hAAAA_0000, -1, 0, 99, -1); // master abort
        run_txn(4'b0111, 32'h0000_0600, 1,  32'h0000_0600, -1, 0, 4,  -1); // claim in expiring clock
        run_txn(4'b0010, 32'h0000_0700, 1,  32'h0000_0000, -1, 0, 0,  -1); // unsupported command
        reset_mid_burst();
`ifdef PCI_INIT_STOP_EN
        run_txn(4'b0111, 32'h0000_0800, 4,  32'h7700_0000, -1, 0, 0,  1);  // disconnect on beat 2
        run_txn(4'b0110, 32'h0000_0900, 4,  32'h6600_0000,  2, 3, 0,  2);  // retry on beat 3
`endif

        repeat (3) @(negedge clk);
        #1;
        chk("pop_q_drained", pop_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("done_q_drained", abort_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
